// File: rtl/sdio_pkg.sv
// Shared SD CMD-line definitions: frame constants, FSM encoding, CRC7 step.
package sdio_pkg;

    localparam int         SD_RESP_LEN  = 48;
    localparam logic [6:0] SD_CRC7_POLY = 7'h09;
    localparam logic [6:0] SD_CRC_R3    = 7'h7F;

    // Common state encoding for the CMD-line sampler and transmitter
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_SEND = 2'd2
    } sd_state_e;

    // One serial step of CRC7 (x^7 + x^3 + 1), MSB-first data
    function automatic logic [6:0] crc7_next(input logic [6:0] crc, input logic b);
        logic fb;
        fb = b ^ crc[6];
        return {crc[5:0], 1'b0} ^ (fb ? SD_CRC7_POLY : 7'h00);
    endfunction

endpackage

// File: rtl/sdio_cmd_resp_tx_if.sv
// Controller <-> response transmitter bundle.
interface sdio_cmd_resp_tx_if;

    logic        start;
    logic        abort;
    logic [5:0]  resp_cmd;
    logic [31:0] resp_arg;
    logic        crc_en;
    logic        cmd_o;
    logic        cmd_oe;
    logic        busy;
    logic        done;

    modport master (
        output start, abort, resp_cmd, resp_arg, crc_en,
        input  cmd_o, cmd_oe, busy, done
    );

    modport slave (
        input  start, abort, resp_cmd, resp_arg, crc_en,
        output cmd_o, cmd_oe, busy, done
    );

endinterface

// File: rtl/sdio_crc7.sv
// Serial CRC7 accumulator; clr wins over en.
module sdio_crc7
    import sdio_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_clr,
    input  logic       i_en,
    input  logic       i_bit,
    output logic [6:0] o_crc
);

    logic [6:0] r_crc;

    // Clear at frame accept, fold in one data bit per enabled cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_crc <= 7'h00;
        else if (i_clr)
            r_crc <= 7'h00;
        else if (i_en)
            r_crc <= crc7_next(r_crc, i_bit);
    end

    assign o_crc = r_crc;

endmodule

// File: rtl/sdio_cmd_resp_tx.sv
// Card-side SD CMD response serialiser: N_CR gap, then 48-bit frame MSB first.
module sdio_cmd_resp_tx
    import sdio_pkg::*;
#(
    parameter int NCR   = 2,
    parameter int CNT_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    sdio_cmd_resp_tx_if.slave io_if
);

    sd_state_e        r_state, w_state_nx;
    logic [CNT_W-1:0] r_cnt, w_cnt_nx;
    logic [39:0]      r_shift, w_shift_nx;
    logic             r_crc_en, w_crc_en_nx;
    logic             r_cmd_o, w_cmd_o_nx;
    logic             r_cmd_oe, w_cmd_oe_nx;
    logic             r_busy, w_busy_nx;
    logic             r_done, w_done_nx;
    logic             w_crc_clr, w_crc_step;
    logic [2:0]       w_crc_idx;
    logic [6:0]       w_crc;

    // CRC covers exactly the bits leaving the shift register (47..8)
    sdio_crc7 u_crc (
        .clk   (clk),
        .rst   (rst),
        .i_clr (w_crc_clr),
        .i_en  (w_crc_step),
        .i_bit (r_shift[39]),
        .o_crc (w_crc)
    );

    // State register; all pin-facing outputs are registered to keep CMD glitch-free
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_shift  <= '0;
            r_crc_en <= 1'b0;
            r_cmd_o  <= 1'b1;
            r_cmd_oe <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_cnt    <= w_cnt_nx;
            r_shift  <= w_shift_nx;
            r_crc_en <= w_crc_en_nx;
            r_cmd_o  <= w_cmd_o_nx;
            r_cmd_oe <= w_cmd_oe_nx;
            r_busy   <= w_busy_nx;
            r_done   <= w_done_nx;
        end
    end

    // Next state and next pin values; r_cnt is the gap counter in WAIT and
    // the index of the bit currently on the pins in SEND
    always_comb begin
        w_state_nx  = r_state;
        w_cnt_nx    = r_cnt;
        w_shift_nx  = r_shift;
        w_crc_en_nx = r_crc_en;
        w_cmd_o_nx  = 1'b1;
        w_cmd_oe_nx = 1'b0;
        w_busy_nx   = r_busy;
        w_done_nx   = 1'b0;
        w_crc_clr   = 1'b0;
        w_crc_step  = 1'b0;
        w_crc_idx   = 3'(r_cnt - CNT_W'(2));
        case (r_state)
            ST_IDLE: begin
                w_busy_nx = 1'b0;
                if (io_if.start) begin
                    w_shift_nx  = {2'b00, io_if.resp_cmd, io_if.resp_arg};
                    w_crc_en_nx = io_if.crc_en;
                    w_crc_clr   = 1'b1;
                    w_cnt_nx    = CNT_W'(NCR - 1);
                    w_state_nx  = ST_WAIT;
                    w_busy_nx   = 1'b1;
                end
            end
            ST_WAIT: begin
                if (io_if.abort) begin
                    w_state_nx = ST_IDLE;
                    w_cnt_nx   = '0;
                    w_busy_nx  = 1'b0;
                end else if (r_cnt == '0) begin
                    // start bit goes out with this edge
                    w_state_nx  = ST_SEND;
                    w_cnt_nx    = CNT_W'(SD_RESP_LEN - 1);
                    w_cmd_o_nx  = r_shift[39];
                    w_cmd_oe_nx = 1'b1;
                    w_shift_nx  = {r_shift[38:0], 1'b0};
                    w_crc_step  = 1'b1;
                end else begin
                    w_cnt_nx = r_cnt - CNT_W'(1);
                end
            end
            ST_SEND: begin
                if (io_if.abort) begin
                    w_state_nx = ST_IDLE;
                    w_cnt_nx   = '0;
                    w_busy_nx  = 1'b0;
                end else if (r_cnt == '0) begin
                    // end bit has been on the pins for a cycle: release
                    w_state_nx = ST_IDLE;
                    w_busy_nx  = 1'b0;
                    w_done_nx  = 1'b1;
                end else begin
                    w_cnt_nx    = r_cnt - CNT_W'(1);
                    w_cmd_oe_nx = 1'b1;
                    if (r_cnt >= CNT_W'(9)) begin
                        w_cmd_o_nx = r_shift[39];
                        w_shift_nx = {r_shift[38:0], 1'b0};
                        w_crc_step = 1'b1;
                    end else if (r_cnt >= CNT_W'(2)) begin
                        // next bit is CRC bit (r_cnt-1), i.e. crc[r_cnt-2]
                        w_cmd_o_nx = r_crc_en ? w_crc[w_crc_idx] : SD_CRC_R3[w_crc_idx];
                    end else begin
                        w_cmd_o_nx = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
                w_busy_nx  = 1'b0;
            end
        endcase
    end

    assign io_if.cmd_o  = r_cmd_o;
    assign io_if.cmd_oe = r_cmd_oe;
    assign io_if.busy   = r_busy;
    assign io_if.done   = r_done;

endmodule
